// File: rtl/cafeteira_pkg.sv
// rtl/cafeteira_pkg.sv - shared types, constants and status-byte packing for the ESP status link
package cafeteira_pkg;

  localparam logic [7:0] HEADER_ESP = 8'hA5;

  // Bit positions of each field inside the status byte
  localparam int BIT_ESTADO_LSB  = 4;
  localparam int BIT_ERRO_AGUA   = 3;
  localparam int BIT_ERRO_XICARA = 2;
  localparam int BIT_EBULIDOR    = 1;
  localparam int BIT_VALVULA     = 0;

  typedef logic [3:0] estado_cafeteira_t;
  typedef logic [2:0] estado_tx_t;

  localparam estado_tx_t OCIOSO  = 3'd0;
  localparam estado_tx_t CARREGA = 3'd1;
  localparam estado_tx_t ENVIA0  = 3'd2;
  localparam estado_tx_t ENVIA1  = 3'd3;
  localparam estado_tx_t ENVIA2  = 3'd4;
  localparam estado_tx_t FIM     = 3'd5;

  function automatic logic [7:0] monta_status(
    input estado_cafeteira_t estado,
    input logic              erro_sem_agua,
    input logic              erro_sem_xicara,
    input logic              ebulidor,
    input logic              valvula
  );
    logic [7:0] s;
    s = '0;
    s[BIT_ESTADO_LSB +: 4] = estado;
    s[BIT_ERRO_AGUA]       = erro_sem_agua;
    s[BIT_ERRO_XICARA]     = erro_sem_xicara;
    s[BIT_EBULIDOR]        = ebulidor;
    s[BIT_VALVULA]         = valvula;
    return s;
  endfunction

endpackage

// File: rtl/transmissor_status_esp_if.sv
// rtl/transmissor_status_esp_if.sv - status inputs and serial outputs of the ESP status transmitter
interface transmissor_status_esp_if;
  import cafeteira_pkg::*;

  logic              enviar;
  estado_cafeteira_t estado;
  logic              erro_sem_agua;
  logic              erro_sem_xicara;
  logic              ebulidor;
  logic              valvula;
  logic              tx_esp;
  logic              ocupado;
  logic              fim_envio;

  modport master (
    output enviar, estado, erro_sem_agua, erro_sem_xicara, ebulidor, valvula,
    input  tx_esp, ocupado, fim_envio
  );

  modport slave (
    input  enviar, estado, erro_sem_agua, erro_sem_xicara, ebulidor, valvula,
    output tx_esp, ocupado, fim_envio
  );

endinterface

// File: rtl/uart_tx_8n1.sv
// rtl/uart_tx_8n1.sv - 8N1 byte serializer, LSB first; accepts the next byte in the last stop-bit cycle
module uart_tx_8n1 #(
  parameter int CICLOS_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [7:0] dado,
  output logic       tx,
  output logic       ocupado,
  output logic       pronto
);

  localparam int W = (CICLOS_BIT > 1) ? $clog2(CICLOS_BIT) : 1;
  localparam logic [W-1:0] CNT_MAX = W'(CICLOS_BIT - 1);

  logic [W-1:0] r_cnt;
  logic [3:0]   r_bit;
  logic [8:0]   r_shift;
  logic         r_tx;
  logic         r_ocupado;
  logic         w_fim_bit;
  logic         w_ultimo;

  assign w_fim_bit = (r_cnt == '0);
  // Last cycle of the stop bit: a new byte loaded here starts with no idle gap
  assign w_ultimo  = r_ocupado && w_fim_bit && (r_bit == 4'd9);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tx      <= 1'b1;
      r_ocupado <= 1'b0;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '1;
    end else if ((!r_ocupado || w_ultimo) && partida) begin
      r_tx      <= 1'b0;
      r_ocupado <= 1'b1;
      r_cnt     <= CNT_MAX;
      r_bit     <= '0;
      r_shift   <= {1'b1, dado};
    end else if (w_ultimo) begin
      r_tx      <= 1'b1;
      r_ocupado <= 1'b0;
    end else if (r_ocupado) begin
      if (w_fim_bit) begin
        r_cnt   <= CNT_MAX;
        r_bit   <= r_bit + 4'd1;
        r_tx    <= r_shift[0];
        r_shift <= {1'b1, r_shift[8:1]};
      end else begin
        r_cnt <= r_cnt - W'(1);
      end
    end
  end

  assign tx      = r_tx;
  assign ocupado = r_ocupado;
  assign pronto  = w_ultimo;

endmodule

// File: rtl/transmissor_status_esp.sv
// rtl/transmissor_status_esp.sv - frames a status snapshot as A5/status/checksum and sends it to the ESP
module transmissor_status_esp
  import cafeteira_pkg::*;
#(
  parameter int          CLOCK_HZ   = 50_000_000,
  parameter int          BAUD       = 115_200,
  parameter logic [7:0]  HEADER     = HEADER_ESP,
  parameter bit          AUTO_ENVIO = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  transmissor_status_esp_if.slave  bus
);

  localparam int CICLOS_BIT = CLOCK_HZ / BAUD;

  estado_tx_t r_estado;
  logic [7:0] r_snapshot;
  logic [7:0] r_ultimo_enviado;
  logic       r_pendente;

  logic [7:0] w_status;
  logic [7:0] w_dado;
  logic       w_gatilho;
  logic       w_partida;
  logic       w_uart_ocupado;
  logic       w_pronto;
  logic       w_tx;

  assign w_status  = monta_status(bus.estado, bus.erro_sem_agua, bus.erro_sem_xicara,
                                  bus.ebulidor, bus.valvula);
  assign w_gatilho = bus.enviar | (AUTO_ENVIO && (w_status != r_ultimo_enviado));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado         <= OCIOSO;
      r_snapshot       <= '0;
      r_ultimo_enviado <= '0;
      r_pendente       <= 1'b0;
    end else begin
      case (r_estado)
        OCIOSO: if (w_gatilho) r_estado <= CARREGA;
        // The status seen here is the one latched, so only a new enviar is pending
        CARREGA: begin
          r_snapshot       <= w_status;
          r_ultimo_enviado <= w_status;
          r_pendente       <= bus.enviar;
          r_estado         <= ENVIA0;
        end
        ENVIA0: begin
          if (w_gatilho) r_pendente <= 1'b1;
          if (w_pronto)  r_estado   <= ENVIA1;
        end
        ENVIA1: begin
          if (w_gatilho) r_pendente <= 1'b1;
          if (w_pronto)  r_estado   <= ENVIA2;
        end
        ENVIA2: begin
          if (w_gatilho) r_pendente <= 1'b1;
          if (w_pronto)  r_estado   <= FIM;
        end
        FIM: begin
          r_pendente <= 1'b0;
          r_estado   <= (r_pendente || w_gatilho) ? CARREGA : OCIOSO;
        end
        default: r_estado <= OCIOSO;
      endcase
    end
  end

  // Header starts from an idle UART; later bytes chain on the stop-bit end
  assign w_partida = ((r_estado == ENVIA0) && !w_uart_ocupado) ||
                     (w_pronto && ((r_estado == ENVIA0) || (r_estado == ENVIA1)));

  always_comb begin
    w_dado = HEADER ^ r_snapshot;
    if (r_estado == ENVIA0) w_dado = w_uart_ocupado ? r_snapshot : HEADER;
  end

  uart_tx_8n1 #(.CICLOS_BIT(CICLOS_BIT)) u_uart (
    .clock   (clock),
    .reset   (reset),
    .partida (w_partida),
    .dado    (w_dado),
    .tx      (w_tx),
    .ocupado (w_uart_ocupado),
    .pronto  (w_pronto)
  );

  assign bus.tx_esp    = w_tx;
  assign bus.ocupado   = (r_estado != OCIOSO) && (r_estado != FIM);
  assign bus.fim_envio = (r_estado == FIM);

endmodule

// File: tb/tb_transmissor_status_esp.sv
// tb/tb_transmissor_status_esp.sv - bench decoding tx_esp against a frame model of the status link
module tb_transmissor_status_esp;

  localparam int CB    = 50_000_000 / 115_200;
  localparam int FRAME = 30 * CB;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int unsigned cyc = 0;
  int tests = 0;
  int fails = 0;

  byte unsigned rx_q[$];
  int unsigned  rx_t[$];
  int unsigned  last_start = 0;
  int           frame_err = 0;
  logic [7:0]   cur_status = 8'h00;

  transmissor_status_esp_if bus();

  transmissor_status_esp #(
    .CLOCK_HZ(50_000_000), .BAUD(115_200), .HEADER(8'hA5), .AUTO_ENVIO(1'b1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Line decoder: samples each bit in its middle, pushes bytes with their start cycle
  initial begin : monitor
    bit          ativo;
    int unsigned n;
    int unsigned s;
    logic [7:0]  b;
    ativo = 0; n = 0; s = 0; b = '0;
    forever begin
      @(negedge clock);
      if (reset) ativo = 0;
      else if (!ativo) begin
        if (bus.tx_esp === 1'b0) begin
          ativo = 1; n = 0; s = cyc; last_start = cyc;
        end
      end else begin
        n++;
        if (n % CB == CB / 2) begin
          int k;
          k = n / CB;
          if (k == 0) begin
            if (bus.tx_esp !== 1'b0) begin frame_err++; ativo = 0; end
          end else if (k <= 8) b[k-1] = bus.tx_esp;
          else begin
            if (bus.tx_esp !== 1'b1) frame_err++;
            rx_q.push_back(b);
            rx_t.push_back(s);
            ativo = 0;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] status_model(int e, int a, int x, int eb, int v);
    return 8'(e * 16 + a * 8 + x * 4 + eb * 2 + v);
  endfunction

  task automatic set_inputs(input int e, input int a, input int x, input int eb, input int v);
    bus.estado          = 4'(e);
    bus.erro_sem_agua   = 1'(a);
    bus.erro_sem_xicara = 1'(x);
    bus.ebulidor        = 1'(eb);
    bus.valvula         = 1'(v);
    cur_status          = status_model(e, a, x, eb, v);
  endtask

  task automatic pulse_enviar();
    bus.enviar = 1'b1;
    @(negedge clock);
    bus.enviar = 1'b0;
  endtask

  task automatic wait_frame(input string tag, input logic [7:0] s, output int unsigned t0);
    int guard;
    guard = 0;
    t0 = 0;
    while (rx_q.size() < 3 && guard < FRAME + 2000) begin @(negedge clock); guard++; end
    check({tag, "_arrived"}, rx_q.size() >= 3, 1);
    if (rx_q.size() >= 3) begin
      check({tag, "_header"}, rx_q[0], 8'hA5);
      check({tag, "_status"}, rx_q[1], s);
      check({tag, "_checksum"}, rx_q[2], 8'hA5 ^ s);
      check({tag, "_gap01"}, rx_t[1] - rx_t[0], 10 * CB);
      check({tag, "_gap12"}, rx_t[2] - rx_t[1], 10 * CB);
      t0 = rx_t[0];
      repeat (3) begin void'(rx_q.pop_front()); void'(rx_t.pop_front()); end
    end
  endtask

  task automatic wait_fim(input string tag, input int unsigned t0);
    int guard;
    guard = 0;
    while (bus.fim_envio !== 1'b1 && guard < 2000) begin @(negedge clock); guard++; end
    check({tag, "_fim_seen"}, bus.fim_envio, 1'b1);
    check({tag, "_fim_time"}, cyc - t0, FRAME);
    check({tag, "_fim_ocupado_low"}, bus.ocupado, 1'b0);
    @(negedge clock);
    check({tag, "_fim_single"}, bus.fim_envio, 1'b0);
  endtask

  task automatic idle_check(input string tag, input int n);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge clock);
      if (bus.tx_esp !== 1'b1 || bus.ocupado !== 1'b0 || bus.fim_envio !== 1'b0) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    int unsigned t0;
    int unsigned t1;
    int unsigned k;
    int unsigned alvo;
    int          guard;
    int          bad;
    int          r;

    bus.enviar = 1'b0;
    set_inputs(0, 0, 0, 0, 0);
    reset = 1'b1;

    // Reset held 2 us, then idle with all inputs zero
    bad = 0;
    repeat (100) begin
      @(negedge clock);
      if (bus.tx_esp !== 1'b1 || bus.ocupado !== 1'b0 || bus.fim_envio !== 1'b0) bad++;
    end
    check("t1_reset_hold", bad, 0);
    reset = 1'b0;
    idle_check("t1_idle", 200);

    // enviar together with a status change at idle: exactly one frame
    k = cyc;
    set_inputs(3, 0, 0, 0, 0);
    pulse_enviar();
    wait_frame("t2", cur_status, t0);
    check("t2_latency", t0, k + 3);
    wait_fim("t2", t0);
    idle_check("t2_single", 300);

    // Automatic frame on a status change, then silence while stable
    k = cyc;
    set_inputs(3, 1, 0, 0, 0);
    wait_frame("t3", cur_status, t0);
    check("t3_latency", t0, k + 3);
    wait_fim("t3", t0);
    idle_check("t3_stable", 2500);

    // Changes and repeated enviar during a frame: frame unchanged, one extra frame
    pulse_enviar();
    begin
      logic [7:0] s1;
      s1 = cur_status;
      repeat ($urandom_range(500, 6000)) @(negedge clock);
      set_inputs(5, 0, 0, 1, 0);
      pulse_enviar();
      repeat (2) begin
        repeat ($urandom_range(10, 2000)) @(negedge clock);
        pulse_enviar();
      end
      wait_frame("t4a", s1, t0);
    end
    wait_fim("t4a", t0);
    check("t4_ocupado_back", bus.ocupado, 1'b1);
    wait_frame("t4b", cur_status, t1);
    check("t4b_start", t1, t0 + FRAME + 3);
    wait_fim("t4b", t1);
    idle_check("t4_no_third", 500);

    // Random status frame aborted by reset in the middle of the checksum byte
    r = $urandom_range(1, 255);
    k = cyc;
    set_inputs(r / 16, (r / 8) % 2, (r / 4) % 2, (r / 2) % 2, r % 2);
    pulse_enviar();
    guard = 0;
    while (rx_q.size() < 2 && guard < FRAME) begin @(negedge clock); guard++; end
    check("t5_two_bytes", rx_q.size() >= 2, 1);
    if (rx_q.size() >= 2) begin
      check("t5_header", rx_q[0], 8'hA5);
      check("t5_status", rx_q[1], cur_status);
      check("t5_latency", rx_t[0], k + 3);
      alvo = rx_t[0] + 23 * CB + $urandom_range(0, 4 * CB);
      guard = 0;
      while (cyc < alvo && guard < 6000) begin @(negedge clock); guard++; end
    end
    #3 reset = 1'b1;
    #1;
    check("t5_abort_tx", bus.tx_esp, 1'b1);
    check("t5_abort_ocupado", bus.ocupado, 1'b0);
    rx_q.delete();
    rx_t.delete();
    set_inputs(0, 0, 0, 0, 0);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    idle_check("t5_no_frame", 300);
    check("t5_no_partial", rx_q.size(), 0);

    // After reset, a status different from 8'h00 triggers a frame on its own
    k = cyc;
    set_inputs(1, 0, 0, 0, 0);
    repeat (10) @(negedge clock);
    check("t5_auto_after_reset", last_start, k + 3);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    set_inputs(0, 0, 0, 0, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    check("framing_errors", frame_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
